// File: rtl/term_scroll_ctrl_if.sv
// Byte-stream and text-buffer/blit bus between a terminal host and term_scroll_ctrl.
// The host (master) supplies bytes and blit_complete; the controller (slave) drives the rest.
interface term_scroll_ctrl_if #(
  parameter int ADDR_W = 11
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              blit_en;
  logic [ADDR_W-1:0] blit_start;
  logic [ADDR_W-1:0] blit_end;
  logic [7:0]        blit_offset;
  logic              blit_complete;

  modport master (
    output in_valid, in_data, blit_complete,
    input  in_ready, wr_en, wr_addr, wr_data, blit_en, blit_start, blit_end, blit_offset
  );

  modport slave (
    input  in_valid, in_data, blit_complete,
    output in_ready, wr_en, wr_addr, wr_data, blit_en, blit_start, blit_end, blit_offset
  );
endinterface

// File: rtl/term_scroll_ctrl.sv
// Terminal write sequencer: cursor tracking, character writes, CR/LF/BS/FF handling,
// and scrolling via one blit followed by a direct clear of the bottom row.
module term_scroll_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 11
) (
  input  logic                clk100,
  input  logic                rst,
  term_scroll_ctrl_if.slave   bus,
  output logic [5:0]          cur_row,
  output logic [6:0]          cur_col,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SCROLL_REQ, SCROLL_WAIT, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] BOTTOM_ROW = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(ROWS * COLS - 1);
  localparam logic [7:0]        SPACE      = 8'h20;

  state_t            state;
  logic [ADDR_W-1:0] clr_last;

  logic              accept;
  logic              is_print;
  logic              is_lf;
  logic              row_last;
  logic              col_last;
  logic              adv_row;
  logic [ADDR_W-1:0] cur_addr;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    is_print = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7e);
    is_lf    = (bus.in_data == 8'h0a);
    row_last = (cur_row == 6'(ROWS - 1));
    col_last = (cur_col == 7'(COLS - 1));
    adv_row  = (is_print && col_last) || is_lf;
    cur_addr = ADDR_W'(cur_row) * ADDR_W'(COLS) + ADDR_W'(cur_col);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      clr_last        <= '0;
      cur_row         <= '0;
      cur_col         <= '0;
      busy            <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.blit_en     <= 1'b0;
      bus.blit_start  <= '0;
      bus.blit_end    <= '0;
      bus.blit_offset <= '0;
    end else begin
      bus.wr_en   <= 1'b0;
      bus.blit_en <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
          if (accept) begin
            if (is_print) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= cur_addr;
              bus.wr_data <= bus.in_data;
              cur_col     <= col_last ? 7'd0 : cur_col + 7'd1;
            end
            if (adv_row && !row_last) cur_row <= cur_row + 6'd1;
            if (adv_row && row_last) begin
              // Row is held at the bottom; the scroll makes room for it.
              state        <= SCROLL_REQ;
              bus.in_ready <= 1'b0;
              busy         <= 1'b1;
            end
            unique case (bus.in_data)
              8'h0d: cur_col <= '0;
              8'h08: if (cur_col != '0) cur_col <= cur_col - 7'd1;
              8'h0c: begin
                cur_row      <= '0;
                cur_col      <= '0;
                state        <= CLEAR;
                bus.in_ready <= 1'b0;
                busy         <= 1'b1;
                bus.wr_en    <= 1'b1;
                bus.wr_addr  <= '0;
                bus.wr_data  <= SPACE;
                clr_last     <= LAST_CELL;
              end
              default: ;
            endcase
          end
        end
        SCROLL_REQ: begin
          bus.blit_en     <= 1'b1;
          bus.blit_start  <= '0;
          bus.blit_end    <= BOTTOM_ROW;
          bus.blit_offset <= 8'(COLS);
          state           <= SCROLL_WAIT;
        end
        SCROLL_WAIT: begin
          if (bus.blit_complete) begin
            state       <= CLEAR;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= BOTTOM_ROW;
            bus.wr_data <= SPACE;
            clr_last    <= LAST_CELL;
          end
        end
        CLEAR: begin
          if (bus.wr_addr == clr_last) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
          end else begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= bus.wr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_term_scroll_ctrl.sv
// Directed bench for term_scroll_ctrl: writes, cursor moves, scroll, form feed, reset mid-scroll.
module tb_term_scroll_ctrl;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic [5:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  term_scroll_ctrl_if #(.ADDR_W(11)) bus ();

  term_scroll_ctrl #(.COLS(80), .ROWS(25), .ADDR_W(11)) dut (
    .clk100  (clk100),
    .rst     (rst),
    .bus     (bus.slave),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #5 clk100 = ~clk100;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  int          blit_cnt = 0;
  int          overlap  = 0;
  int          cyc      = 0;

  always @(negedge clk100) begin
    cyc <= cyc + 1;
    if (bus.wr_en) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_cyc.push_back(cyc);
    end
    if (bus.blit_en) blit_cnt <= blit_cnt + 1;
    if (bus.wr_en && bus.blit_en) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.blit_complete = 1'b0;
    repeat (2) @(negedge clk100);
    rst = 1'b0;
    @(negedge clk100);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!bus.in_ready && t < 5000) begin
      @(negedge clk100);
      t++;
    end
    if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    @(negedge clk100);
    bus.in_valid = 1'b0;
  endtask

  task automatic goto(input int row, input int col);
    for (int i = 0; i < row; i++) send_byte(8'h0a);
    for (int i = 0; i < col; i++) send_byte(8'h2e);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (!bus.in_ready && t < budget) begin
      @(negedge clk100);
      t++;
    end
    check(tag, 32'(bus.in_ready), 32'd1);
  endtask

  // Checks n space writes at consecutive addresses from base_addr, queued from index qi.
  task automatic check_clear(input string tag, input int qi, input int base_addr, input int n);
    int bad = 0;
    check({tag, "_count"}, 32'(wq_addr.size() - qi), 32'(n));
    for (int i = 0; i < n && qi + i < wq_addr.size(); i++) begin
      if (wq_addr[qi+i] != 11'(base_addr + i) || wq_data[qi+i] != 8'h20) bad++;
      if (i > 0 && wq_cyc[qi+i] != wq_cyc[qi+i-1] + 1) bad++;
    end
    check({tag, "_bad_cells"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int qi;
    int bi;

    // Reset state
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.blit_complete = 1'b0;
    repeat (2) @(negedge clk100);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_blit_en", 32'(bus.blit_en), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_blit_end", 32'(bus.blit_end), 32'd0);
    check("rst_cursor", {cur_row, cur_col}, 32'd0);
    rst = 1'b0;
    @(negedge clk100);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: 'A','B' back-to-back
    qi = wq_addr.size();
    send_byte(8'h41);
    send_byte(8'h42);
    @(negedge clk100);
    check("t1_count", 32'(wq_addr.size() - qi), 32'd2);
    check("t1_addr0", 32'(wq_addr[qi]), 32'd0);
    check("t1_data0", 32'(wq_data[qi]), 32'h41);
    check("t1_addr1", 32'(wq_addr[qi+1]), 32'd1);
    check("t1_data1", 32'(wq_data[qi+1]), 32'h42);
    check("t1_consecutive", 32'(wq_cyc[qi+1] - wq_cyc[qi]), 32'd1);
    check("t1_row", 32'(cur_row), 32'd0);
    check("t1_col", 32'(cur_col), 32'd2);

    // 2: 80 printable bytes wrap to the next row
    do_reset();
    qi = wq_addr.size();
    bi = blit_cnt;
    for (int i = 0; i < 80; i++) send_byte(8'h30 + 8'(i % 10));
    @(negedge clk100);
    check("t2_count", 32'(wq_addr.size() - qi), 32'd80);
    check("t2_last_addr", 32'(wq_addr[wq_addr.size()-1]), 32'd79);
    check("t2_last_data", 32'(wq_data[wq_data.size()-1]), 32'h39);
    check("t2_row", 32'(cur_row), 32'd1);
    check("t2_col", 32'(cur_col), 32'd0);
    check("t2_no_blit", 32'(blit_cnt - bi), 32'd0);

    // 3: LF on the bottom row scrolls
    do_reset();
    goto(24, 5);
    @(negedge clk100);
    qi = wq_addr.size();
    bi = blit_cnt;
    send_byte(8'h0a);
    check("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk100);
    check("t3_blit_count", 32'(blit_cnt - bi), 32'd1);
    check("t3_blit_start", 32'(bus.blit_start), 32'd0);
    check("t3_blit_end", 32'(bus.blit_end), 32'd1920);
    check("t3_blit_offset", 32'(bus.blit_offset), 32'd80);
    check("t3_busy", 32'(busy), 32'd1);
    repeat (7) @(negedge clk100);
    check("t3_wait_no_writes", 32'(wq_addr.size() - qi), 32'd0);
    bus.blit_complete = 1'b1;
    @(negedge clk100);
    bus.blit_complete = 1'b0;
    wait_idle("t3_idle", 200);
    check_clear("t3_clear", qi, 1920, 80);
    check("t3_row", 32'(cur_row), 32'd24);
    check("t3_col", 32'(cur_col), 32'd5);
    check("t3_busy_after", 32'(busy), 32'd0);

    // 4: form feed clears the whole screen
    do_reset();
    goto(7, 30);
    @(negedge clk100);
    qi = wq_addr.size();
    bi = blit_cnt;
    send_byte(8'h0c);
    wait_idle("t4_idle", 3000);
    check_clear("t4_clear", qi, 0, 2000);
    check("t4_cursor", {cur_row, cur_col}, 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_blit", 32'(blit_cnt - bi), 32'd0);

    // 5: BS saturation, CR, dropped control byte
    do_reset();
    goto(3, 0);
    @(negedge clk100);
    send_byte(8'h08);
    check("t5_bs_row", 32'(cur_row), 32'd3);
    check("t5_bs_col", 32'(cur_col), 32'd0);
    send_byte(8'h71);
    send_byte(8'h71);
    send_byte(8'h08);
    check("t5_bs_dec", 32'(cur_col), 32'd1);
    send_byte(8'h0d);
    check("t5_cr_col", 32'(cur_col), 32'd0);
    qi = wq_addr.size();
    send_byte(8'h01);
    @(negedge clk100);
    check("t5_drop_writes", 32'(wq_addr.size() - qi), 32'd0);
    check("t5_drop_cursor", {cur_row, cur_col}, {19'd0, 6'd3, 7'd0});

    // Printable in the last cell: write, wrap column, hold row, scroll
    do_reset();
    goto(24, 79);
    @(negedge clk100);
    qi = wq_addr.size();
    bi = blit_cnt;
    send_byte(8'h5a);
    repeat (3) @(negedge clk100);
    check("t7_addr", 32'(wq_addr[qi]), 32'd1999);
    check("t7_data", 32'(wq_data[qi]), 32'h5a);
    check("t7_cursor", {cur_row, cur_col}, {19'd0, 6'd24, 7'd0});
    check("t7_blit", 32'(blit_cnt - bi), 32'd1);

    // 6: reset during SCROLL_WAIT, late blit_complete ignored
    do_reset();
    goto(24, 0);
    send_byte(8'h0a);
    repeat (3) @(negedge clk100);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk100);
    check("t6_rst_outputs", {bus.wr_en, bus.blit_en, bus.in_ready, busy, bus.wr_addr, bus.blit_end},
          32'd0);
    check("t6_rst_blit_offset", 32'(bus.blit_offset), 32'd0);
    check("t6_rst_cursor", {cur_row, cur_col}, 32'd0);
    rst = 1'b0;
    qi = wq_addr.size();
    @(negedge clk100);
    bus.blit_complete = 1'b1;
    @(negedge clk100);
    bus.blit_complete = 1'b0;
    repeat (5) @(negedge clk100);
    check("t6_no_clear", 32'(wq_addr.size() - qi), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);

    check("wr_blit_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
